// File: rtl/mem_stream_client.sv
// Stream-to-SDRAM client: packs 32-bit input pairs into 64-bit writes, then reads them back as a stream.
// Optional build macro MEM_STREAM_CLIENT_CSUM_EN adds csum_err, a write/read XOR checksum compare.
module mem_stream_client #(
    parameter int ADDR_W  = 13,
    parameter int DEPTH   = 8192,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              rd_start,
    output logic              rd_done,
    output logic              full,
    output logic              err,
    output logic [ADDR_W:0]   wr_count,
    output logic              mem_go,
    output logic              mem_w_rn,
    output logic [ADDR_W-1:0] mem_address,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata,
    input  logic              mem_valid
`ifdef MEM_STREAM_CLIENT_CSUM_EN
    ,
    output logic              csum_err
`endif
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, FILL_LO, ISSUE_W, WAIT_W,
        ISSUE_R, WAIT_R, EMIT_HI, EMIT_LO
    } state_t;

    state_t          state;
    logic [TW-1:0]   tmo;
    logic [ADDR_W:0] rd_addr;
    logic [31:0]     hold_lo;
    logic [ADDR_W:0] rd_next;
    logic [ADDR_W:0] wr_next;

    assign rd_next = rd_addr + (ADDR_W + 1)'(1);
    assign wr_next = wr_count + (ADDR_W + 1)'(1);
    assign full    = (wr_count == DEPTH_C);

    // Transaction sequencer; every output is registered from the next-state decision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            rd_done     <= 1'b0;
            err         <= 1'b0;
            wr_count    <= '0;
            mem_go      <= 1'b0;
            mem_w_rn    <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            rd_addr     <= '0;
            hold_lo     <= '0;
            tmo         <= '0;
        end else begin
            mem_go  <= 1'b0;
            rd_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    in_ready <= !full;
                    if (rd_start) begin
                        if (wr_count == '0) begin
                            rd_done <= 1'b1;
                        end else begin
                            rd_addr     <= '0;
                            mem_go      <= 1'b1;
                            mem_w_rn    <= 1'b0;
                            mem_address <= '0;
                            in_ready    <= 1'b0;
                            state       <= ISSUE_R;
                        end
                    end else if (in_valid && in_ready) begin
                        mem_wdata[63:32] <= in_data;
                        in_ready         <= 1'b1;
                        state            <= FILL_LO;
                    end
                end
                FILL_LO: begin
                    if (in_valid) begin
                        mem_wdata[31:0] <= in_data;
                        in_ready        <= 1'b0;
                        mem_go          <= 1'b1;
                        mem_w_rn        <= 1'b1;
                        mem_address     <= wr_count[ADDR_W-1:0];
                        state           <= ISSUE_W;
                    end
                end
                ISSUE_W: begin
                    tmo   <= TW'(1);
                    state <= WAIT_W;
                end
                WAIT_W: begin
                    if (mem_valid) begin
                        wr_count <= wr_next;
                        in_ready <= (wr_next != DEPTH_C);
                        state    <= IDLE;
                    end else if (tmo == TMO_LAST) begin
                        err      <= 1'b1;
                        in_ready <= !full;
                        state    <= IDLE;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                ISSUE_R: begin
                    tmo   <= TW'(1);
                    state <= WAIT_R;
                end
                WAIT_R: begin
                    if (mem_valid) begin
                        hold_lo   <= mem_rdata[31:0];
                        out_data  <= mem_rdata[63:32];
                        out_valid <= 1'b1;
                        state     <= EMIT_HI;
                    end else if (tmo == TMO_LAST) begin
                        err      <= 1'b1;
                        in_ready <= !full;
                        state    <= IDLE;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                EMIT_HI: begin
                    if (out_ready) begin
                        out_data <= hold_lo;
                        state    <= EMIT_LO;
                    end
                end
                EMIT_LO: begin
                    if (out_ready) begin
                        rd_addr   <= rd_next;
                        out_valid <= 1'b0;
                        if (rd_next == wr_count) begin
                            rd_done  <= 1'b1;
                            in_ready <= !full;
                            state    <= IDLE;
                        end else begin
                            mem_go      <= 1'b1;
                            mem_w_rn    <= 1'b0;
                            mem_address <= rd_next[ADDR_W-1:0];
                            state       <= ISSUE_R;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_STREAM_CLIENT_CSUM_EN
    logic [63:0] wr_csum;
    logic [63:0] rd_csum;

    // Fold written and read-back words into XOR sums; compare them as rd_done fires.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_csum  <= '0;
            rd_csum  <= '0;
            csum_err <= 1'b0;
        end else begin
            if (state == ISSUE_W)
                wr_csum <= wr_csum ^ mem_wdata;
            if (state == IDLE && rd_start) begin
                rd_csum  <= '0;
                csum_err <= (wr_count == '0) ? (wr_csum != '0) : 1'b0;
            end
            if (state == WAIT_R && mem_valid)
                rd_csum <= rd_csum ^ mem_rdata;
            if (state == EMIT_LO && out_ready && rd_next == wr_count)
                csum_err <= (wr_csum != rd_csum);
        end
    end
`endif

endmodule

// File: tb/tb_mem_stream_client.sv
// Directed bench for mem_stream_client with a behavioural SDRAM controller model.
// Runs a DEPTH=4 instance so the full/back-pressure corner is reachable.
module tb_mem_stream_client;

    localparam int AW = 13;
    localparam int DP = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          rd_start = 1'b0;
    logic          rd_done;
    logic          full;
    logic          err;
    logic [AW:0]   wr_count;
    logic          mem_go;
    logic          mem_w_rn;
    logic [AW-1:0] mem_address;
    logic [63:0]   mem_wdata;
    logic [63:0]   mem_rdata = '0;
    logic          mem_valid = 1'b0;
`ifdef MEM_STREAM_CLIENT_CSUM_EN
    logic          csum_err;
`endif

    always #5 clk = ~clk;

    mem_stream_client #(.ADDR_W(AW), .DEPTH(DP), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .rd_start(rd_start), .rd_done(rd_done), .full(full), .err(err),
        .wr_count(wr_count), .mem_go(mem_go), .mem_w_rn(mem_w_rn),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid)
`ifdef MEM_STREAM_CLIENT_CSUM_EN
        , .csum_err(csum_err)
`endif
    );

    int          lat = 10;
    bit          drop = 1'b0;
    int          corrupt_addr = -1;
    int          go_n = 0;
    int          rd_n = 0;
    int          rdone_n = 0;
    logic        last_w_rn = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [63:0] last_wdata = '0;
    logic [AW-1:0] rd_log [0:63];
    logic [63:0] mem_arr [0:15];
    int          cnt = 0;
    bit          active = 1'b0;
    logic [63:0] rdv = '0;

    function automatic logic [63:0] rd_word(input logic [AW-1:0] a);
        return mem_arr[a[3:0]] ^ ((int'(a) == corrupt_addr) ? 64'h1 : 64'h0);
    endfunction

    // Controller model: answers each mem_go with mem_valid lat cycles later.
    always @(posedge clk) begin
        mem_valid <= 1'b0;
        if (rd_done) rdone_n <= rdone_n + 1;
        if (!rst) begin
            active <= 1'b0;
        end else begin
            if (active) begin
                if (cnt <= 1) begin
                    mem_valid <= 1'b1;
                    mem_rdata <= rdv;
                    active    <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (mem_go) begin
                go_n       <= go_n + 1;
                last_w_rn  <= mem_w_rn;
                last_addr  <= mem_address;
                last_wdata <= mem_wdata;
                if (mem_w_rn) begin
                    mem_arr[mem_address[3:0]] <= mem_wdata;
                end else begin
                    if (rd_n < 64) rd_log[rd_n] <= mem_address;
                    rd_n <= rd_n + 1;
                end
                if (!drop) begin
                    if (lat <= 1) begin
                        mem_valid <= 1'b1;
                        mem_rdata <= rd_word(mem_address);
                    end else begin
                        active <= 1'b1;
                        cnt    <= lat - 1;
                        rdv    <= rd_word(mem_address);
                    end
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        rd_start = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] w);
        int n = 0;
        in_data = w;
        in_valid = 1'b1;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("push_wait", 64'(in_ready), 64'd1);
        else @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pull(input logic [31:0] e, input string name);
        int n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'({out_valid, out_data}), 64'({1'b1, e}));
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic wait_wr(input int n);
        int k = 0;
        while (wr_count != (AW + 1)'(n) && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("wr_count", 64'(wr_count), 64'(n));
    endtask

    task automatic pulse_rd();
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
    endtask

    typedef struct {
        logic [31:0]   din;
        logic [31:0]   exp;
        logic [AW-1:0] addr;
    } vec_t;

    vec_t vec [6];

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int g0;
        int r0;
        int d0;
        int got;
        int n;
        bit stalled;
        bit seen;
        logic [31:0] held;

        vec[0] = '{32'h1, 32'h1, 13'd0};
        vec[1] = '{32'h2, 32'h2, 13'd0};
        vec[2] = '{32'h3, 32'h3, 13'd1};
        vec[3] = '{32'h4, 32'h4, 13'd1};
        vec[4] = '{32'h5, 32'h5, 13'd2};
        vec[5] = '{32'h6, 32'h6, 13'd2};

        // reset state
        repeat (2) @(negedge clk);
        chk("reset_flags", 64'({in_ready, out_valid, mem_go, err, full, rd_done, mem_w_rn}), 64'd0);
        chk("reset_words", 64'({wr_count, out_data, mem_address}), 64'd0);
        chk("reset_wdata", mem_wdata, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(in_ready), 64'd1);

        // single write, 10-cycle controller latency
        lat = 10;
        g0 = go_n;
        push(32'hDEADBEEF);
        push(32'h01234567);
        wait_wr(1);
        chk("t1_go_n", 64'(go_n - g0), 64'd1);
        chk("t1_w_rn", 64'(last_w_rn), 64'd1);
        chk("t1_addr", 64'(last_addr), 64'd0);
        chk("t1_wdata", last_wdata, 64'hDEADBEEF_01234567);

        // three writes then read-back, table driven
        do_reset();
        lat = 3;
        for (int i = 0; i < 6; i++) push(vec[i].din);
        wait_wr(3);
        chk("t2_full", 64'(full), 64'd0);
        chk("t2_mem0", mem_arr[0], 64'h00000001_00000002);
        chk("t2_mem1", mem_arr[1], 64'h00000003_00000004);
        chk("t2_mem2", mem_arr[2], 64'h00000005_00000006);
        r0 = rd_n;
        d0 = rdone_n;
        pulse_rd();
        for (int i = 0; i < 6; i++) pull(vec[i].exp, $sformatf("t2_out%0d", i));
        chk("t2_rd_done", 64'(rd_done), 64'd1);
        @(negedge clk);
        chk("t2_rd_done_pulse", 64'({rd_done, 8'(rdone_n - d0)}), 64'h001);
        chk("t2_rd_n", 64'(rd_n - r0), 64'd3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("t2_rd_addr%0d", k), 64'(rd_log[r0 + k]), 64'(vec[2 * k].addr));

        // read-back again with out_ready toggling
        d0 = rdone_n;
        pulse_rd();
        got = 0;
        n = 0;
        stalled = 1'b0;
        held = '0;
        while (got < 6 && n < 400) begin
            out_ready = ~out_ready;
            if (out_valid) begin
                if (stalled) chk("t3_stable", 64'(out_data), 64'(held));
                if (out_ready) begin
                    chk($sformatf("t3_out%0d", got), 64'(out_data), 64'(vec[got].exp));
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = out_data;
                end
            end else begin
                stalled = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
        chk("t3_count", 64'(got), 64'd6);
        chk("t3_rd_done", 64'(rd_done), 64'd1);
        @(negedge clk);
        chk("t3_rd_done_n", 64'(rdone_n - d0), 64'd1);
        chk("t3_wr_kept", 64'(wr_count), 64'd3);

        // write timeout
        do_reset();
        drop = 1'b1;
        g0 = go_n;
        push(32'hAAAA0000);
        push(32'hBBBB1111);
        n = 0;
        while (!mem_go && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t4_go", 64'(mem_go), 64'd1);
        repeat (TO - 1) @(negedge clk);
        chk("t4_err_early", 64'(err), 64'd0);
        @(negedge clk);
        chk("t4_err", 64'(err), 64'd1);
        chk("t4_idle", 64'({in_ready, wr_count}), 64'({1'b1, 14'd0}));
        repeat (4) @(negedge clk);
        chk("t4_go_n", 64'(go_n - g0), 64'd1);
        drop = 1'b0;
        lat = 2;
        push(32'hCCCC0000);
        push(32'hDDDD1111);
        wait_wr(1);
        chk("t4_err_sticky", 64'(err), 64'd1);
        chk("t4_wdata", last_wdata, 64'hCCCC0000_DDDD1111);

        // fill to DEPTH=4, back-pressure, read-back still allowed
        do_reset();
        lat = 2;
        g0 = go_n;
        for (int i = 0; i < 8; i++) push(32'h100 + 32'(i));
        wait_wr(4);
        chk("t5_full", 64'(full), 64'd1);
        in_data = 32'h108;
        in_valid = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (in_ready) seen = 1'b1;
        end
        chk("t5_backpressure", 64'(seen), 64'd0);
        chk("t5_go_n", 64'(go_n - g0), 64'd4);
        pulse_rd();
        for (int i = 0; i < 8; i++) pull(32'h100 + 32'(i), $sformatf("t5_out%0d", i));
        chk("t5_rd_done", 64'(rd_done), 64'd1);
        @(negedge clk);
        chk("t5_still_full", 64'({in_ready, full, wr_count}), 64'({1'b0, 1'b1, 14'd4}));
        in_valid = 1'b0;

        // rd_start priority and empty read
        do_reset();
        g0 = go_n;
        in_data = 32'hBAD0BAD0;
        in_valid = 1'b1;
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        in_valid = 1'b0;
        chk("t6_empty_done", 64'(rd_done), 64'd1);
        @(negedge clk);
        chk("t6_done_pulse", 64'(rd_done), 64'd0);
        repeat (3) @(negedge clk);
        chk("t6_no_go", 64'(go_n - g0), 64'd0);
        push(32'h0000000A);
        push(32'h0000000B);
        wait_wr(1);
        chk("t6_wdata", last_wdata, 64'h0000000A_0000000B);
        in_data = 32'h0000000C;
        in_valid = 1'b1;
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        in_valid = 1'b0;
        pull(32'h0000000A, "t6_out0");
        pull(32'h0000000B, "t6_out1");
        chk("t6_rd_done", 64'(rd_done), 64'd1);
        chk("t6_read_go", 64'({last_w_rn, last_addr}), 64'd0);

`ifdef MEM_STREAM_CLIENT_CSUM_EN
        // checksum mismatch from one corrupted read
        do_reset();
        lat = 2;
        push(32'h1);
        push(32'h2);
        push(32'h3);
        push(32'h4);
        wait_wr(2);
        corrupt_addr = 0;
        pulse_rd();
        pull(32'h1, "cs_out0");
        pull(32'h3, "cs_out1");
        pull(32'h3, "cs_out2");
        pull(32'h4, "cs_out3");
        chk("cs_err_set", 64'({rd_done, csum_err}), 64'h3);
        corrupt_addr = -1;
        pulse_rd();
        chk("cs_err_clr", 64'(csum_err), 64'd0);
        pull(32'h1, "cs_out4");
        pull(32'h2, "cs_out5");
        pull(32'h3, "cs_out6");
        pull(32'h4, "cs_out7");
        chk("cs_err_ok", 64'({rd_done, csum_err}), 64'h2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
